// File: rtl/writeback_arbiter.sv
// writeback_arbiter: register-file write-back stage.
// Merges a never-stalling ALU result stream with a valid/ready load-return
// stream (buffered in a DEPTH-entry FIFO) into one registered write per cycle.
// Optional feature macro: WB_FWD_EN enables forwarding of pending results to
// the two operand-read addresses; when undefined the forwarding outputs are
// tied to zero and no compare logic exists.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iAluValid,
    input  logic [ADDR_WIDTH-1:0] iAluAddr,
    input  logic [DATA_WIDTH-1:0] iAluData,
    input  logic                  iLdValid,
    output logic                  oLdReady,
    input  logic [ADDR_WIDTH-1:0] iLdAddr,
    input  logic [DATA_WIDTH-1:0] iLdData,
    output logic                  oEnWrite,
    output logic [ADDR_WIDTH-1:0] oAddrWrite,
    output logic [DATA_WIDTH-1:0] oDataWrite,
    input  logic [ADDR_WIDTH-1:0] iAddrRead0,
    input  logic [ADDR_WIDTH-1:0] iAddrRead1,
    output logic                  oFwdHit0,
    output logic [DATA_WIDTH-1:0] oFwdData0,
    output logic                  oFwdHit1,
    output logic [DATA_WIDTH-1:0] oFwdData1,
    output logic                  oBusy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]           FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]           CNT_ZERO   = {(PW+1){1'b0}};
    localparam logic [PW:0]           CNT_ONE    = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0]         PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    // FIFO storage and control state
    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW:0]           count_q, count_d;

    // Output write register
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Per-cycle decisions
    logic alu_wr_s;
    logic ld_ready_s;
    logic ld_push_s;
    logic fifo_empty_s;
    logic pop_s;
    logic bypass_s;
    logic ld_drop_s;
    logic enq_s;
    logic head_valid_s;

    // Arbitration decisions for this cycle (ALU > FIFO head > bypassed load)
    always_comb begin
        alu_wr_s     = iAluValid && (iAluAddr != ADDR_ZERO);
        ld_ready_s   = !iRst && (count_q < FULL_COUNT);
        ld_push_s    = iLdValid && ld_ready_s;
        fifo_empty_s = (count_q == CNT_ZERO);
        pop_s        = !alu_wr_s && !fifo_empty_s;
        bypass_s     = !alu_wr_s && fifo_empty_s && ld_push_s;
        // A same-cycle load to the ALU's register is older and thus dead.
        ld_drop_s    = alu_wr_s && (iLdAddr == iAluAddr);
        enq_s        = ld_push_s && !bypass_s && !ld_drop_s;
        head_valid_s = valid_q[rd_ptr_q];
    end

    // Next-state for FIFO contents, pointers, count and write register
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        valid_d     = valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        en_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        // A younger ALU write kills every queued load to the same register;
        // the slot stays occupied and pops as a no-write.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr_s && (fifo_addr_q[i] == iAluAddr)) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end

        if (enq_s) begin
            fifo_addr_d[wr_ptr_q] = iLdAddr;
            fifo_data_d[wr_ptr_q] = iLdData;
            valid_d[wr_ptr_q]     = (iLdAddr != ADDR_ZERO);
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (alu_wr_s) begin
            en_d    = 1'b1;
            waddr_d = iAluAddr;
            wdata_d = iAluData;
        end else if (pop_s) begin
            en_d = head_valid_s;
            if (head_valid_s) begin
                waddr_d = fifo_addr_q[rd_ptr_q];
                wdata_d = fifo_data_q[rd_ptr_q];
            end else begin
                waddr_d = waddr_q;
                wdata_d = wdata_q;
            end
        end else if (bypass_s) begin
            en_d = (iLdAddr != ADDR_ZERO);
            if (iLdAddr != ADDR_ZERO) begin
                waddr_d = iLdAddr;
                wdata_d = iLdData;
            end else begin
                waddr_d = waddr_q;
                wdata_d = wdata_q;
            end
        end else begin
            en_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= ADDR_ZERO;
                fifo_data_q[i] <= DATA_ZERO;
            end
            valid_q  <= {DEPTH{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= CNT_ZERO;
            en_q     <= 1'b0;
            waddr_q  <= ADDR_ZERO;
            wdata_q  <= DATA_ZERO;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            valid_q     <= valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            en_q        <= en_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign oLdReady   = ld_ready_s;
    assign oEnWrite   = en_q;
    assign oAddrWrite = waddr_q;
    assign oDataWrite = wdata_q;
    assign oBusy      = (count_q != CNT_ZERO) || en_q;

`ifdef WB_FWD_EN
    // Youngest pending value for raddr: output register first, then FIFO
    // entries oldest-to-youngest so the youngest valid match wins.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] raddr);
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        logic [PW-1:0]         idx;
        hit  = 1'b0;
        data = DATA_ZERO;
        if (en_q && (waddr_q == raddr)) begin
            hit  = 1'b1;
            data = wdata_q;
        end else begin
            hit  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && valid_q[idx] && (fifo_addr_q[idx] == raddr)) begin
                hit  = 1'b1;
                data = fifo_data_q[idx];
            end else begin
                hit = hit;
            end
        end
        if (raddr == ADDR_ZERO) begin
            hit  = 1'b0;
            data = DATA_ZERO;
        end else begin
            hit = hit;
        end
        return {hit, data};
    endfunction

    assign {oFwdHit0, oFwdData0} = fwd_lookup(iAddrRead0);
    assign {oFwdHit1, oFwdData1} = fwd_lookup(iAddrRead1);
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{iAddrRead0, iAddrRead1};
    assign oFwdHit0  = 1'b0;
    assign oFwdData0 = DATA_ZERO;
    assign oFwdHit1  = 1'b0;
    assign oFwdData1 = DATA_ZERO;
`endif

endmodule
